vjtag_dr_bank: RTL and testbench
================================

Name: vjtag_dr_bank

Overview:
Parametrised data-register bank behind the virtual JTAG hub, clocked entirely in the tck domain. It decodes the virtual IR and provides N_REGS read/write DR chains of DR_WIDTH bits, a read-only ID register and a 1-bit BYPASS register. Each chain loads from a per-register capture bus, shifts LSB-first and commits to a per-register update bus with a one-cycle strobe. It also returns an update counter to the host through ir_out on every IR capture.

Parameters:
IR_WIDTH, 4, width of ir_in/ir_out; legal range 2..8.
DR_WIDTH, 32, width of every data register and the ID register; minimum 2.
N_REGS, 4, number of R/W registers; must satisfy 1 <= N_REGS <= 2^IR_WIDTH-2.
ID_VALUE, 32'h5654_4D31, constant captured by the ID register; width DR_WIDTH.
RESET_VAL, 0, reset value of every upd_data slice; width DR_WIDTH.

Ports:
tck  in  1  JTAG clock from the virtual JTAG hub; the block's only clock.
reset_n  in  1  asynchronous active-low reset.
tdi  in  1  serial data from the hub.
tdo  out  1  serial data to the hub.
ir_in  in  IR_WIDTH  current virtual IR value.
ir_out  out  IR_WIDTH  value returned to the host during IR capture.
virtual_state_cdr  in  1  Capture-DR.
virtual_state_sdr  in  1  Shift-DR.
virtual_state_e1dr  in  1  Exit1-DR.
virtual_state_pdr  in  1  Pause-DR.
virtual_state_e2dr  in  1  Exit2-DR.
virtual_state_udr  in  1  Update-DR.
virtual_state_cir  in  1  Capture-IR.
virtual_state_uir  in  1  Update-IR.
cap_data  in  N_REGS*DR_WIDTH  capture value; slice k (bits k*DR_WIDTH +: DR_WIDTH) belongs to register k.
upd_data  out  N_REGS*DR_WIDTH  committed register contents; slice k belongs to register k.
upd_stb  out  N_REGS  bit k pulses for one tck cycle when register k commits.
sel_ir  out  IR_WIDTH  IR value latched at Update-IR.

Behaviour:
- Clocking: one clock, tck. Reset is asynchronous and active-low on reset_n. All state is on rising tck.
- IR decode, from ir_in:
  - 0 = BYPASS.
  - 1..N_REGS = R/W register k = ir_in-1.
  - all-ones = ID.
  - any other code = BYPASS.
- Reset, while reset_n=0:
  - shift_reg=0, bypass_reg=0, upd_data slices=RESET_VAL, upd_stb=0, upd_cnt=0, ir_out=0, sel_ir=0.
  - A reset in the middle of a shift discards the partial shift. upd_data does not change until a new, complete Update-DR.
- Capture-DR (cdr=1):
  - R/W register k: shift_reg <= cap_data slice k.
  - ID: shift_reg <= ID_VALUE.
  - BYPASS: bypass_reg <= 0.
- Shift-DR (sdr=1):
  - BYPASS: bypass_reg <= tdi.
  - Otherwise: shift_reg <= {tdi, shift_reg[DR_WIDTH-1:1]}, LSB out first.
  - After exactly DR_WIDTH shifts, shift_reg holds the shifted-in word, first bit in the LSB. Extra shifts keep pushing bits out; no error is flagged.
- tdo is combinational: bypass_reg when BYPASS is decoded, otherwise shift_reg[0].
- Exit1-DR, Pause-DR and Exit2-DR: all registers hold.
- Update-DR (udr=1):
  - R/W register k: upd_data slice k <= shift_reg; upd_stb[k]=1 on the next cycle only; upd_cnt <= upd_cnt+1, wrapping modulo 2^IR_WIDTH.
  - ID or BYPASS: no data change, no strobe, no count.
- upd_stb is a registered single-cycle pulse. Back-to-back Update-DR on consecutive cycles gives one pulse per update.
- Capture-IR (cir=1): ir_out <= upd_cnt. It holds until the next cir or reset.
- Update-IR (uir=1): sel_ir <= ir_in.
- Simultaneous assertion of state strobes is illegal. If it occurs, the priority is cdr > sdr > udr; cir and uir are evaluated independently of the DR strobes.
- If Update-DR and Capture-IR occur in the same cycle, ir_out takes the pre-increment upd_cnt.
- ir_in is sampled on every cycle; no ir_in stability is required beyond one cycle.
- Target size: about 150-250 lines of RTL.

Test Plan:
1. Reset, then IR=1 (reg 0); cap_data slice0=32'hDEADBEEF; cdr then 32 sdr with tdi=bits of 32'h12345678 LSB-first -> tdo emits EF,BE,AD,DE bytes LSB-first. udr -> upd_data slice0=32'h12345678 and upd_stb=4'b0001 for exactly one cycle.
2. IR=4'hF, cdr plus 32 sdr -> tdo streams 32'h56544D31 LSB-first. A following udr leaves upd_data unchanged and upd_stb=0.
3. IR=0 and then IR=4'h9 (unmapped): cdr, sdr with tdi=1,0,1 -> tdo=0,1,0 (one-cycle delay) in both cases. udr has no effect.
4. Perform 17 updates on reg 2, then cir -> ir_out=4'h1 (17 mod 16). uir with ir_in=4'h3 -> sel_ir=4'h3.
5. Shift 20 of 32 bits into reg 1, assert reset_n=0 for one cycle, release -> upd_data slice1=RESET_VAL, upd_stb=0, ir_out=0. A new full 32-bit shift plus udr commits correctly.
6. Pause mid-shift: 16 sdr, e1dr, 5 pdr cycles, e2dr, 16 sdr, udr -> committed word equals the 32 shifted-in bits; shift_reg is unchanged across the pause.

Source files
------------

// File: rtl/vjtag_dr_bank.sv
// Virtual-JTAG data-register bank: N_REGS R/W chains, an ID register and BYPASS,
// all clocked on tck. Also returns an update counter through ir_out at Capture-IR.

module vjtag_dr_slot #(
    parameter int                    DR_WIDTH  = 32,
    parameter logic [DR_WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                tck,
    input  logic                reset_n,
    input  logic                commit,
    input  logic [DR_WIDTH-1:0] din,
    output logic [DR_WIDTH-1:0] q,
    output logic                stb
);
    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            q   <= RESET_VAL;
            stb <= 1'b0;
        end else begin
            stb <= commit;
            if (commit) q <= din;
        end
    end
endmodule

module vjtag_dr_bank #(
    parameter int                    IR_WIDTH  = 4,
    parameter int                    DR_WIDTH  = 32,
    parameter int                    N_REGS    = 4,
    parameter logic [DR_WIDTH-1:0]   ID_VALUE  = 32'h5654_4D31,
    parameter logic [DR_WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic                         tck,
    input  logic                         reset_n,
    input  logic                         tdi,
    output logic                         tdo,
    input  logic [IR_WIDTH-1:0]          ir_in,
    output logic [IR_WIDTH-1:0]          ir_out,
    input  logic                         virtual_state_cdr,
    input  logic                         virtual_state_sdr,
    input  logic                         virtual_state_e1dr,
    input  logic                         virtual_state_pdr,
    input  logic                         virtual_state_e2dr,
    input  logic                         virtual_state_udr,
    input  logic                         virtual_state_cir,
    input  logic                         virtual_state_uir,
    input  logic [N_REGS*DR_WIDTH-1:0]   cap_data,
    output logic [N_REGS*DR_WIDTH-1:0]   upd_data,
    output logic [N_REGS-1:0]            upd_stb,
    output logic [IR_WIDTH-1:0]          sel_ir
);
    localparam logic [IR_WIDTH-1:0] IR_ID = '1;

    logic [N_REGS-1:0]   reg_sel;
    logic                hit_rw, hit_id, hit_byp;
    logic [DR_WIDTH-1:0] cap_word;
    logic [DR_WIDTH-1:0] shift_reg;
    logic                bypass_reg;
    logic [IR_WIDTH-1:0] upd_cnt;
    logic                dr_pause;
    logic                do_cdr, do_sdr, do_udr;
    logic [N_REGS-1:0]   commit;

    // One-hot register select; codes above N_REGS other than all-ones fall to BYPASS.
    always_comb begin
        reg_sel  = '0;
        cap_word = '0;
        for (int k = 0; k < N_REGS; k++) begin
            reg_sel[k] = (ir_in == IR_WIDTH'(k + 1));
            if (reg_sel[k]) cap_word = cap_data[k*DR_WIDTH +: DR_WIDTH];
        end
        hit_id  = (ir_in == IR_ID);
        hit_rw  = |reg_sel;
        hit_byp = !hit_rw && !hit_id;
    end

    // Strobe priority cdr > sdr > udr; a hold state alongside udr is a glitched
    // TAP, so holding is the safe choice there.
    assign dr_pause = virtual_state_e1dr | virtual_state_pdr | virtual_state_e2dr;
    assign do_cdr   = virtual_state_cdr;
    assign do_sdr   = virtual_state_sdr & ~virtual_state_cdr;
    assign do_udr   = virtual_state_udr & ~virtual_state_cdr & ~virtual_state_sdr & ~dr_pause;

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            shift_reg  <= '0;
            bypass_reg <= 1'b0;
        end else if (do_cdr) begin
            if (hit_rw)      shift_reg  <= cap_word;
            else if (hit_id) shift_reg  <= ID_VALUE;
            else             bypass_reg <= 1'b0;
        end else if (do_sdr) begin
            if (hit_byp) bypass_reg <= tdi;
            else         shift_reg  <= {tdi, shift_reg[DR_WIDTH-1:1]};
        end
    end

    assign tdo = hit_byp ? bypass_reg : shift_reg[0];

    always_ff @(posedge tck or negedge reset_n) begin
        if (!reset_n) begin
            upd_cnt <= '0;
            ir_out  <= '0;
            sel_ir  <= '0;
        end else begin
            if (do_udr && hit_rw) upd_cnt <= upd_cnt + 1'b1;
            // Same-cycle udr+cir returns the pre-increment count.
            if (virtual_state_cir) ir_out <= upd_cnt;
            if (virtual_state_uir) sel_ir <= ir_in;
        end
    end

    assign commit = reg_sel & {N_REGS{do_udr}};

    genvar g;
    generate
        for (g = 0; g < N_REGS; g++) begin : g_slot
            vjtag_dr_slot #(
                .DR_WIDTH  (DR_WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_slot (
                .tck     (tck),
                .reset_n (reset_n),
                .commit  (commit[g]),
                .din     (shift_reg),
                .q       (upd_data[g*DR_WIDTH +: DR_WIDTH]),
                .stb     (upd_stb[g])
            );
        end
    endgenerate
endmodule

// File: tb/tb_vjtag_dr_bank.sv
// Scoreboard bench for vjtag_dr_bank: stimulus pushes expectations, a negedge
// monitor pops them as tdo shifts, strobes fire or tagged state checks fall due.
`timescale 1ns/1ps
module tb_vjtag_dr_bank;
    localparam int IRW = 4;
    localparam int DW  = 32;
    localparam int NR  = 4;
    localparam logic [DW-1:0] ID_VAL = 32'h5654_4D31;

    logic tck = 1'b0;
    logic reset_n, tdi, tdo;
    logic [IRW-1:0] ir_in, ir_out, sel_ir;
    logic cdr, sdr, e1dr, pdr, e2dr, udr, cir, uir;
    logic [NR*DW-1:0] cap_data, upd_data;
    logic [NR-1:0] upd_stb;

    vjtag_dr_bank #(.IR_WIDTH(IRW), .DR_WIDTH(DW), .N_REGS(NR)) dut (
        .tck(tck), .reset_n(reset_n), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .virtual_state_cdr(cdr), .virtual_state_sdr(sdr),
        .virtual_state_e1dr(e1dr), .virtual_state_pdr(pdr),
        .virtual_state_e2dr(e2dr), .virtual_state_udr(udr),
        .virtual_state_cir(cir), .virtual_state_uir(uir),
        .cap_data(cap_data), .upd_data(upd_data), .upd_stb(upd_stb), .sel_ir(sel_ir)
    );

    always #5 tck = ~tck;

    int cyc = 0;
    always @(posedge tck) cyc <= cyc + 1;

    typedef struct { int tag; int fld; int idx; logic [31:0] val; } chk_t;
    typedef struct { logic [NR-1:0] stb; int idx; logic [DW-1:0] data; } upd_t;
    chk_t st_q[$];
    upd_t up_q[$];
    bit   tdo_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
        end
    endtask

    // Monitor: tdo during shift, strobe pulses, and due state checks.
    always @(negedge tck) begin
        if (sdr && !cdr) begin
            if (tdo_q.size() == 0) chk("tdo_unexpected", 32'd1, 32'd0);
            else chk("tdo", {31'd0, tdo}, {31'd0, tdo_q.pop_front()});
        end
        if (upd_stb != '0) begin
            if (up_q.size() == 0) chk("upd_stb_spurious", {28'd0, upd_stb}, 32'd0);
            else begin
                upd_t u;
                u = up_q.pop_front();
                chk("upd_stb", {28'd0, upd_stb}, {28'd0, u.stb});
                chk("upd_data_commit", upd_data[u.idx*DW +: DW], u.data);
            end
        end
        while (st_q.size() != 0 && st_q[0].tag <= cyc) begin
            chk_t c;
            c = st_q.pop_front();
            case (c.fld)
                0:       chk($sformatf("upd_data[%0d]", c.idx), upd_data[c.idx*DW +: DW], c.val);
                1:       chk("upd_stb_idle", {28'd0, upd_stb}, c.val);
                2:       chk("ir_out", {28'd0, ir_out}, c.val);
                default: chk("sel_ir", {28'd0, sel_ir}, c.val);
            endcase
        end
    end

    // Bench model of the DR path (expected values come from here and from constants).
    logic [DW-1:0] m_sh;
    logic          m_byp;
    int            m_cnt;
    logic [DW-1:0] exp_data [NR];

    function automatic int kind(input logic [IRW-1:0] ir);
        if (ir >= 1 && ir <= NR) return 1;
        if (ir == 4'hF)          return 2;
        return 0;
    endfunction

    task automatic clr();
        cdr = 0; sdr = 0; e1dr = 0; pdr = 0; e2dr = 0; udr = 0; cir = 0; uir = 0;
    endtask

    task automatic tick();
        @(posedge tck); #1;
        clr();
    endtask

    task automatic expect_now(input int fld, input int idx, input logic [31:0] v);
        chk_t c;
        c.tag = cyc; c.fld = fld; c.idx = idx; c.val = v;
        st_q.push_back(c);
    endtask

    task automatic expect_slices();
        for (int k = 0; k < NR; k++) expect_now(0, k, exp_data[k]);
    endtask

    task automatic do_reset();
        reset_n = 0;
        m_sh = '0; m_byp = 0; m_cnt = 0;
        for (int k = 0; k < NR; k++) exp_data[k] = '0;
        tick();
        reset_n = 1;
    endtask

    task automatic cap(input logic [IRW-1:0] ir);
        ir_in = ir; cdr = 1;
        case (kind(ir))
            1:       m_sh  = cap_data[(ir-1)*DW +: DW];
            2:       m_sh  = ID_VAL;
            default: m_byp = 1'b0;
        endcase
        tick();
    endtask

    task automatic shift(input logic b);
        sdr = 1; tdi = b;
        if (kind(ir_in) == 0) begin
            tdo_q.push_back(m_byp);
            m_byp = b;
        end else begin
            tdo_q.push_back(m_sh[0]);
            m_sh = {b, m_sh[DW-1:1]};
        end
        tick();
    endtask

    task automatic shift_bits(input logic [DW-1:0] w, input int lo, input int hi);
        for (int i = lo; i < hi; i++) shift(w[i]);
    endtask

    // Update-DR; with_cir also raises Capture-IR in the same cycle.
    task automatic upd(input bit with_cir);
        udr = 1; cir = with_cir;
        if (kind(ir_in) == 1) begin
            upd_t u;
            u.idx = ir_in - 1; u.stb = NR'(1) << u.idx; u.data = m_sh;
            exp_data[u.idx] = m_sh;
            up_q.push_back(u);
            m_cnt = (m_cnt + 1) % 16;
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr(); tdi = 0; ir_in = '0; cap_data = '0; reset_n = 0;
        do_reset();
        tick();
        expect_slices(); expect_now(1, 0, 0); expect_now(2, 0, 0); expect_now(3, 0, 0);
        tick();

        // 1: reg 0 capture/shift/update
        cap_data[0*DW +: DW] = 32'hDEAD_BEEF;
        cap(4'h1);
        shift_bits(32'h1234_5678, 0, 32);
        upd(0);
        expect_now(0, 0, 32'h1234_5678);
        tick();
        expect_now(1, 0, 0);
        tick();

        // 2: ID streams constant, update is inert
        cap(4'hF);
        shift_bits(32'h0F0F_0F0F, 0, 32);
        upd(0);
        expect_slices(); expect_now(1, 0, 0);
        tick();

        // 3: bypass for code 0 and unmapped code 9
        cap(4'h0); shift(1); shift(0); shift(1); upd(0);
        expect_now(1, 0, 0);
        cap(4'h9); shift(1); shift(0); shift(1); upd(0);
        expect_slices(); expect_now(1, 0, 0);
        tick();

        // 4: 17 back-to-back updates wrap the counter to 1
        do_reset();
        cap_data[2*DW +: DW] = 32'h0BAD_F00D;
        cap(4'h3);
        for (int i = 0; i < 17; i++) upd(0);
        expect_now(0, 2, 32'h0BAD_F00D);
        cir = 1; tick();
        expect_now(2, 0, 32'h1);
        ir_in = 4'h3; uir = 1; tick();
        expect_now(3, 0, 32'h3);
        tick();

        // 5: reset mid-shift clears committed data and discards the partial shift
        cap_data[1*DW +: DW] = 32'h1111_2222;
        cap(4'h2);
        shift_bits(32'hA5A5_0F0F, 0, 32);
        upd(0);
        cir = 1; tick();
        expect_now(0, 1, 32'hA5A5_0F0F); expect_now(2, 0, 32'h2);
        cap(4'h2);
        shift_bits(32'h3C3C_C3C3, 0, 20);
        tdo_q.delete();
        do_reset();
        expect_now(0, 1, 32'h0); expect_now(1, 0, 0); expect_now(2, 0, 0);
        tick();
        cap(4'h2);
        shift_bits(32'hCAFE_F00D, 0, 32);
        upd(0);
        expect_now(0, 1, 32'hCAFE_F00D);
        tick();

        // 6: pause mid-shift, then udr+cir together returns pre-increment count
        cap_data[3*DW +: DW] = 32'h8765_4321;
        cap(4'h4);
        shift_bits(32'h7E57_AB1E, 0, 16);
        e1dr = 1; tick();
        for (int i = 0; i < 5; i++) begin pdr = 1; tick(); end
        e2dr = 1; tick();
        shift_bits(32'h7E57_AB1E, 16, 32);
        upd(1);
        expect_now(0, 3, 32'h7E57_AB1E); expect_now(2, 0, 32'h1);
        cir = 1; tick();
        expect_now(2, 0, 32'h2);
        expect_slices();
        tick(); tick();

        chk("tdo_q_drained", tdo_q.size(), 0);
        chk("upd_q_drained", up_q.size(), 0);
        chk("st_q_drained", st_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
